clock_div_ctrl: RTL and testbench
=================================

// Module: clock_div_ctrl
//
// PURPOSE
//   Run-time programmable, glitch-free clock divider controller for slow peripheral clocks.
//   Generates clk_o = clk_i / div, where div is even, and a one-cycle tick_o at each rising clk_o.
//   Supports safe start/stop and divisor reconfiguration through a valid/ready config port.
//   Enable and divisor changes take effect only at output-period boundaries.
//
// PARAMETERS
//   DivWidth    16  width of the divisor; legal divisors are even values 2 .. 2**DivWidth-2
//   DefaultDiv   2  divisor loaded at reset; must be even, >=2 and fit DivWidth (else $fatal)
//
// PORTS
//   clk_i        in   1         system clock
//   rst_ni       in   1         asynchronous active-low reset
//   en_i         in   1         level enable; 1 = run the divided clock, 0 = stop it
//   cfg_valid_i  in   1         divisor update request
//   cfg_ready_o  out  1         1 when a request can be accepted (= ~pend_q)
//   cfg_div_i    in   DivWidth  requested divisor
//   cfg_err_o    out  1         one-cycle pulse: accepted request was zero or odd and is ignored
//   clk_o        out  1         divided clock, registered
//   tick_o       out  1         one-cycle pulse in the first clk_i cycle that clk_o is high
//   running_o    out  1         1 while state != IDLE
//
// BEHAVIOUR
//   Reset (async): state=IDLE, clk_o=0, tick_o=0, cfg_err_o=0, cnt=0, div_q=DefaultDiv, pend_q=0.
//   Arithmetic: half = div_q>>1. cnt is DivWidth-1 bits and counts 0..half-1.
//     toggle = (cnt == half-1). Period end = toggle with clk_o==1, i.e. the falling edge.
//   States:
//     IDLE: clk_o=0, cnt=0. If en_i=1, go to RUN next cycle with cnt=0.
//     RUN:  each cycle, toggle ? (cnt<=0, clk_o<=~clk_o) : cnt<=cnt+1.
//           If en_i=0, go to STOP; counting continues unchanged.
//     STOP: counting continues. At period end, clk_o<=0 and state goes to IDLE.
//           If en_i=1 again before that, return to RUN with no phase disturbance.
//   tick_o <= toggle & ~clk_o & (state != IDLE); it is high in the cycle after a rising toggle.
//   Divisor 2: clk_o toggles every cycle, giving a 50% duty cycle.
//   Config handshake: a transfer occurs on cfg_valid_i & cfg_ready_o.
//     Illegal value (zero or odd): no state change; cfg_err_o=1 in the next cycle.
//     Legal value in IDLE: div_q<=cfg_div_i next cycle; pend_q stays 0.
//     Legal value in RUN/STOP: pend_div<=cfg_div_i and pend_q<=1, so cfg_ready_o=0.
//       At the next period end: div_q<=pend_div, cnt<=0, pend_q<=0.
//     A transfer in the same cycle as a period end is applied at the following period end.
//     A pending value still present when STOP reaches IDLE is applied on that same cycle.
//   clk_o has no runt pulses: every high and low phase lasts exactly half cycles of the
//     div_q in force when that phase began.
//   Reset asserted mid-operation: immediate return to reset values. A pending update is
//     discarded and div_q reverts to DefaultDiv.
//   Outputs are registered except cfg_ready_o. No combinational path from inputs to clk_o.
//
// TESTING
//   1. Reset, en_i=1, default div 2: clk_o toggles every cycle from the 2nd cycle;
//      tick_o pulses every 2 cycles; running_o=1.
//   2. In IDLE, cfg_div_i=6 accepted, then en_i=1: clk_o high 3 cycles, low 3 cycles;
//      tick_o once per 6 cycles.
//   3. Running at div 6, cfg_div_i=10 accepted mid high phase: cfg_ready_o=0 until the next
//      falling edge, then phases are 5/5; no phase shorter than 3 cycles.
//   4. cfg_div_i=7, then cfg_div_i=0: each gives one cfg_err_o pulse; div_q and clk_o
//      period unchanged.
//   5. Running at div 8, en_i=0 for 1 cycle in the high phase: clk_o stays periodic and
//      running_o stays 1. en_i=0 held: clk_o falls at the period end, running_o=0 next cycle.
//   6. rst_ni low mid high phase with an update pending: clk_o=0, cfg_ready_o=1 and
//      running_o=0 immediately. Restart runs at DefaultDiv.

Source files
------------

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: run-time programmable, glitch-free even clock divider.
// clk_o = clk_i / div_q with a one-cycle tick_o at every rising clk_o.
// Enable changes and divisor updates take effect only at the end of an
// output period (the falling edge of clk_o), so clk_o never produces a
// runt phase.
module clock_div_ctrl #(
  parameter int unsigned DivWidth   = 16,
  parameter int unsigned DefaultDiv = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [DivWidth-1:0] cfg_div_i,
  output logic                cfg_err_o,
  output logic                clk_o,
  output logic                tick_o,
  output logic                running_o
);

  // Reject parameterisations that cannot produce a legal reset divisor.
  if ((DivWidth < 32'd2) ||
      (DefaultDiv < 32'd2) ||
      ((DefaultDiv % 32'd2) != 32'd0) ||
      ((DivWidth < 32'd32) && ((DefaultDiv >> DivWidth) != 32'd0))) begin : g_bad_default
    $fatal(1, "clock_div_ctrl: DefaultDiv must be even, >= 2 and fit in DivWidth bits");
  end

  localparam logic [DivWidth-1:0] DefaultDivW = DefaultDiv[DivWidth-1:0];
  localparam logic [DivWidth-2:0] CntZero     = {(DivWidth-1){1'b0}};
  localparam logic [DivWidth-2:0] CntOne      = {{(DivWidth-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } state_e;

  // A divisor is usable when it is non-zero and even; any such value that
  // fits DivWidth bits is automatically <= 2**DivWidth-2.
  function automatic logic div_legal(input logic [DivWidth-1:0] d);
    return (d != {DivWidth{1'b0}}) && (d[0] == 1'b0);
  endfunction

  state_e                state_r;
  logic [DivWidth-2:0]   cnt_r;
  logic [DivWidth-1:0]   div_r;
  logic [DivWidth-1:0]   pend_div_r;
  logic                  pend_r;
  logic                  clk_r;
  logic                  tick_r;
  logic                  err_r;
  logic                  running_r;

  logic [DivWidth-2:0]   half_s;
  logic [DivWidth-2:0]   cnt_step_s;
  logic                  toggle_s;
  logic                  period_end_s;
  logic                  xfer_s;
  logic                  legal_s;

  // Half-period counter decode and config handshake qualification.
  always_comb begin
    half_s       = div_r[DivWidth-1:1];
    toggle_s     = (cnt_r == (half_s - CntOne));
    period_end_s = toggle_s & clk_r;
    xfer_s       = cfg_valid_i & ~pend_r;
    legal_s      = div_legal(cfg_div_i);
    if (toggle_s) begin
      cnt_step_s = CntZero;
    end else begin
      cnt_step_s = cnt_r + CntOne;
    end
  end

  // Divider FSM, counter, divisor registers and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= StIdle;
      cnt_r      <= CntZero;
      div_r      <= DefaultDivW;
      pend_div_r <= DefaultDivW;
      pend_r     <= 1'b0;
      clk_r      <= 1'b0;
      tick_r     <= 1'b0;
      err_r      <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      // An accepted zero or odd divisor is dropped and flagged for one cycle.
      err_r <= xfer_s & ~legal_s;

      case (state_r)
        StIdle: begin
          clk_r  <= 1'b0;
          cnt_r  <= CntZero;
          tick_r <= 1'b0;
          pend_r <= 1'b0;
          // Nothing is being generated, so a legal divisor applies at once.
          if (xfer_s && legal_s) begin
            div_r <= cfg_div_i;
          end
          if (en_i) begin
            state_r   <= StRun;
            running_r <= 1'b1;
          end else begin
            state_r   <= StIdle;
            running_r <= 1'b0;
          end
        end

        StRun, StStop: begin
          tick_r <= toggle_s & ~clk_r;
          if (period_end_s && pend_r) begin
            // Falling edge closes the period: swap in the queued divisor.
            clk_r  <= 1'b0;
            cnt_r  <= CntZero;
            div_r  <= pend_div_r;
            pend_r <= 1'b0;
          end else begin
            if (toggle_s) begin
              clk_r <= ~clk_r;
            end
            cnt_r <= cnt_step_s;
            // A legal update while running is held until the next period end.
            if (xfer_s && legal_s) begin
              pend_div_r <= cfg_div_i;
              pend_r     <= 1'b1;
            end
          end
          // Re-enabling during STOP resumes without touching the phase;
          // otherwise STOP only parks once the current period has completed.
          if (en_i) begin
            state_r   <= StRun;
            running_r <= 1'b1;
          end else if ((state_r == StStop) && period_end_s) begin
            state_r   <= StIdle;
            running_r <= 1'b0;
          end else begin
            state_r   <= StStop;
            running_r <= 1'b1;
          end
        end

        default: begin
          state_r   <= StIdle;
          cnt_r     <= CntZero;
          clk_r     <= 1'b0;
          tick_r    <= 1'b0;
          pend_r    <= 1'b0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready_o = ~pend_r;
  assign cfg_err_o   = err_r;
  assign clk_o       = clk_r;
  assign tick_o      = tick_r;
  assign running_o   = running_r;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: reset, default divide-by-2, divisor
// programming in idle, pending update while running, illegal divisors,
// enable glitches and stop, and asynchronous reset with an update pending.
module tb_clock_div_ctrl;

  localparam int unsigned DivWidth = 16;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                en_i;
  logic                cfg_valid_i;
  logic                cfg_ready_o;
  logic [DivWidth-1:0] cfg_div_i;
  logic                cfg_err_o;
  logic                clk_o;
  logic                tick_o;
  logic                running_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cap_clk;
  logic [31:0] cap_tick;
  logic [31:0] cap_rdy;
  logic [31:0] cap_err;
  logic [31:0] cap_run;

  clock_div_ctrl #(
    .DivWidth  (DivWidth),
    .DefaultDiv(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_div_i  (cfg_div_i),
    .cfg_err_o  (cfg_err_o),
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .running_o  (running_o)
  );

  // 10 ns system clock.
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cap();
    cap_clk  = 32'h0;
    cap_tick = 32'h0;
    cap_rdy  = 32'h0;
    cap_err  = 32'h0;
    cap_run  = 32'h0;
  endtask

  // Advance one clk_i cycle and shift every output into its capture vector
  // (oldest sample ends up in the highest bit).
  task automatic cyc();
    @(posedge clk_i);
    #1;
    cap_clk  = {cap_clk[30:0], clk_o};
    cap_tick = {cap_tick[30:0], tick_o};
    cap_rdy  = {cap_rdy[30:0], cfg_ready_o};
    cap_err  = {cap_err[30:0], cfg_err_o};
    cap_run  = {cap_run[30:0], running_o};
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    en_i        = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_div_i   = 16'd0;
    clr_cap();

    // 1. Reset state, then default divide-by-2.
    cycn(2);
    chk("rst_clk",   {31'd0, clk_o},       32'd0);
    chk("rst_tick",  {31'd0, tick_o},      32'd0);
    chk("rst_err",   {31'd0, cfg_err_o},   32'd0);
    chk("rst_run",   {31'd0, running_o},   32'd0);
    chk("rst_ready", {31'd0, cfg_ready_o}, 32'd1);
    rst_ni = 1'b1;
    clr_cap();
    cycn(8);
    chk("div2_clk",  cap_clk,  32'b01010101);
    chk("div2_tick", cap_tick, 32'b01010101);
    chk("div2_run",  cap_run,  32'b11111111);
    en_i = 1'b0;
    clr_cap();
    cycn(4);
    chk("div2_stop_clk",  cap_clk,  32'b0100);
    chk("div2_stop_tick", cap_tick, 32'b0100);
    chk("div2_stop_run",  cap_run,  32'b1100);

    // 2. Program divide-by-6 while idle, then run.
    clr_cap();
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd6;
    cyc();
    cfg_valid_i = 1'b0;
    chk("idle_cfg_err",   cap_err, 32'd0);
    chk("idle_cfg_run",   cap_run, 32'd0);
    chk("idle_cfg_ready", {31'd0, cfg_ready_o}, 32'd1);
    en_i = 1'b1;
    clr_cap();
    cycn(13);
    chk("div6_clk",  cap_clk,  32'b0001110001110);
    chk("div6_tick", cap_tick, 32'b0001000001000);

    // 3. Request divide-by-10 in the middle of a high phase.
    cycn(4);
    clr_cap();
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd10;
    cyc();
    cfg_valid_i = 1'b0;
    cycn(11);
    chk("upd10_clk",   cap_clk,  32'b100000111110);
    chk("upd10_ready", cap_rdy,  32'b011111111111);
    chk("upd10_tick",  cap_tick, 32'b000000100000);

    // 4. Odd and zero divisors are rejected without disturbing the period.
    clr_cap();
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd7;
    cyc();
    cfg_valid_i = 1'b0;
    cyc();
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd0;
    cyc();
    cfg_valid_i = 1'b0;
    cycn(7);
    chk("bad_err",   cap_err, 32'b1010000000);
    chk("bad_clk",   cap_clk, 32'b0000111110);
    chk("bad_ready", cap_rdy, 32'b1111111111);

    // 5. Move to divide-by-8, glitch en_i low for one cycle, then stop.
    clr_cap();
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd8;
    cyc();
    cfg_valid_i = 1'b0;
    cycn(9);
    chk("upd8_clk",   cap_clk, 32'b0000111110);
    chk("upd8_ready", cap_rdy, 32'b0000000001);
    clr_cap();
    cycn(5);
    en_i = 1'b0;
    cyc();
    en_i = 1'b1;
    cycn(7);
    chk("glitch_clk", cap_clk, 32'b0001111000011);
    chk("glitch_run", cap_run, 32'b1111111111111);
    clr_cap();
    en_i = 1'b0;
    cycn(4);
    chk("stop8_clk", cap_clk, 32'b1100);
    chk("stop8_run", cap_run, 32'b1100);

    // 6. Asynchronous reset during a high phase with an update pending.
    en_i = 1'b1;
    clr_cap();
    cycn(5);
    chk("pre_rst_clk", cap_clk, 32'b00001);
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd12;
    cyc();
    cfg_valid_i = 1'b0;
    chk("pend_ready", {31'd0, cfg_ready_o}, 32'd0);
    chk("pend_clk",   {31'd0, clk_o},       32'd1);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_clk",   {31'd0, clk_o},       32'd0);
    chk("async_rst_ready", {31'd0, cfg_ready_o}, 32'd1);
    chk("async_rst_run",   {31'd0, running_o},   32'd0);
    chk("async_rst_tick",  {31'd0, tick_o},      32'd0);
    #1;
    rst_ni = 1'b1;
    clr_cap();
    cycn(10);
    chk("restart_clk",   cap_clk,  32'b0101010101);
    chk("restart_tick",  cap_tick, 32'b0101010101);
    chk("restart_ready", cap_rdy,  32'b1111111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
